// File: rtl/data_memory_ctrl.sv
// Data memory controller: one outstanding byte/half/word load or store per request,
// with a fixed access wait, alignment/range fault detection and a one-cycle response.
module data_memory_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned INIT_WORDS = 11;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Power-up image: words 0..10 hold 10 down to 0, everything else zero.
    function automatic logic [DEPTH-1:0][31:0] mem_init();
        logic [DEPTH-1:0][31:0] m;
        m = '0;
        for (int unsigned i = 0; (i < INIT_WORDS) && (i < DEPTH); i++) begin
            m[i] = 32'(INIT_WORDS - 1 - i);
        end
        return m;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, rvalid_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         size_q;
    logic               we_q;
    logic               ld_unsigned_q;
    logic               cap_c;
    logic               mem_we_c;

    logic [DEPTH-1:0][31:0] mem_q = mem_init();

    logic [IDX_W-1:0]   idx_c;
    logic [1:0]         lane_c;
    logic [4:0]         sh_c;
    logic [31:0]        word_c;
    logic [31:0]        rd_sh_c;
    logic               err_c;
    logic [31:0]        load_c;
    logic [31:0]        wmask_c;
    logic [31:0]        wval_c;
    logic [31:0]        wr_word_c;

    assign idx_c   = addr_q[IDX_W+1:2];
    assign lane_c  = addr_q[1:0];
    assign sh_c    = {lane_c, 3'b000};
    assign word_c  = mem_q[idx_c];
    assign rd_sh_c = word_c >> sh_c;

    assign err_c = (size_q == SZ_RSVD)
                 | ((size_q == SZ_HALF) & addr_q[0])
                 | ((size_q == SZ_WORD) & (lane_c != 2'b00))
                 | (addr_q[31:2] >= 30'(DEPTH));

    // Lane extraction for loads and byte-lane merge for stores.
    always_comb begin
        load_c  = '0;
        wmask_c = '0;
        wval_c  = '0;
        case (size_q)
            SZ_BYTE: begin
                load_c  = ld_unsigned_q ? {24'd0, rd_sh_c[7:0]}
                                        : {{24{rd_sh_c[7]}}, rd_sh_c[7:0]};
                wmask_c = 32'h0000_00FF << sh_c;
                wval_c  = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                load_c  = ld_unsigned_q ? {16'd0, rd_sh_c[15:0]}
                                        : {{16{rd_sh_c[15]}}, rd_sh_c[15:0]};
                wmask_c = 32'h0000_FFFF << sh_c;
                wval_c  = {2{wdata_q[15:0]}};
            end
            SZ_WORD: begin
                load_c  = rd_sh_c;
                wmask_c = '1;
                wval_c  = wdata_q;
            end
            default: ;
        endcase
    end

    assign wr_word_c = (word_c & ~wmask_c) | (wval_c & wmask_c);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cap_c    = 1'b0;
        mem_we_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(WAIT);
                    cap_c   = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    err_d    = err_c;
                    rdata_d  = (err_c || we_q) ? '0 : load_c;
                    mem_we_c = we_q && !err_c;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= (state_d == IDLE);
            rvalid_q <= (state_d == RESP);
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            we_q          <= 1'b0;
            ld_unsigned_q <= 1'b0;
        end else if (cap_c) begin
            addr_q        <= addr;
            wdata_q       <= wdata;
            size_q        <= size;
            we_q          <= we;
            ld_unsigned_q <= ld_unsigned;
        end
    end

    // Storage has no reset so contents survive rst_n; writes only fire from BUSY.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_c] <= wr_word_c;
        end
    end

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: driver queues expected responses at acceptance,
// a negedge monitor pops and compares on every rvalid.
module tb_data_memory_ctrl;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned WAIT  = 1;

    logic        clk, rst_n, req, we, ld_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        ready, rvalid, err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    bit   last_hold = 0;

    data_memory_ctrl #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .we(we), .size(size),
        .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Present one request, wait (bounded) for acceptance, then queue its expected response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee,
                         input bit hold, input bit expect_resp);
        int   n;
        exp_t e;
        @(negedge clk);
        we = w; size = sz; ld_unsigned = uns; addr = a; wdata = wd; req = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: ready stayed 0 for addr 0x%08h", a);
            req = 1'b0;
            last_hold = 0;
        end else begin
            @(posedge clk);
            #1;
            if (last_hold) chk("accept_spacing", 32'(cyc - last_acc), 32'(WAIT + 3));
            last_acc  = cyc;
            last_hold = hold;
            if (expect_resp) begin
                e.rdata = er;
                e.err   = ee;
                e.acc   = cyc;
                exp_q.push_back(e);
            end
            if (!hold) req = 1'b0;
            we          = 1'($urandom);
            size        = 2'($urandom);
            ld_unsigned = 1'($urandom);
            addr        = $urandom;
            wdata       = $urandom;
        end
    endtask

    logic        prev_rvalid = 1'b0;
    logic [31:0] last_rdata  = '0;
    logic        last_err    = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            prev_rvalid = 1'b0;
            last_rdata  = '0;
            last_err    = 1'b0;
        end else begin
            if (prev_rvalid) chk("ready_after_resp", 32'(ready), 32'd1);
            if (rvalid) begin
                chk("ready_in_resp", 32'(ready), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid: rdata=0x%08h err=%0b with nothing outstanding", rdata, err);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", rdata, e.rdata);
                    chk("err", 32'(err), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc), 32'(WAIT + 1));
                end
                last_rdata = rdata;
                last_err   = err;
            end else begin
                chk("rdata_hold", rdata, last_rdata);
                chk("err_hold", 32'(err), 32'(last_err));
            end
            prev_rvalid = rvalid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req = 1'b0; we = 1'b0; size = 2'b00; ld_unsigned = 1'b0; addr = '0; wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ready", 32'(ready), 32'd1);
        chk("rst_async_rvalid", 32'(rvalid), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Initial image and byte store/extension
        issue(1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'h0000000A, 1'b0, 0, 1);
        issue(1'b1, 2'b00, 1'b0, 32'h5,   32'h123456A5, 32'h0,        1'b0, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        32'h0000A509, 1'b0, 0, 1);
        issue(1'b0, 2'b00, 1'b0, 32'h5,   32'h0,        32'hFFFFFFA5, 1'b0, 0, 1);
        issue(1'b0, 2'b00, 1'b1, 32'h5,   32'h0,        32'h000000A5, 1'b0, 0, 1);
        // Misalignment faults leave memory intact
        issue(1'b0, 2'b01, 1'b0, 32'h3,   32'h0,        32'h0,        1'b1, 0, 1);
        issue(1'b1, 2'b10, 1'b0, 32'h6,   32'hFFFFFFFF, 32'h0,        1'b1, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        32'h0000A509, 1'b0, 0, 1);
        // Range and reserved-size faults
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 0, 1);
        issue(1'b1, 2'b11, 1'b0, 32'h0,   32'hFFFFFFFF, 32'h0,        1'b1, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'h0000000A, 1'b0, 0, 1);
        // Half store/load in upper lane
        issue(1'b1, 2'b01, 1'b0, 32'h6,   32'h55558001, 32'h0,        1'b0, 0, 1);
        issue(1'b0, 2'b01, 1'b0, 32'h6,   32'h0,        32'hFFFF8001, 1'b0, 0, 1);
        issue(1'b0, 2'b01, 1'b1, 32'h6,   32'h0,        32'h00008001, 1'b0, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        32'h8001A509, 1'b0, 0, 1);
        // Last in-range word
        issue(1'b1, 2'b10, 1'b0, 32'hFC,  32'h12345678, 32'h0,        1'b0, 0, 1);
        issue(1'b0, 2'b00, 1'b0, 32'hFF,  32'h0,        32'h00000012, 1'b0, 0, 1);
        issue(1'b0, 2'b01, 1'b1, 32'hFE,  32'h0,        32'h00001234, 1'b0, 0, 1);
        issue(1'b0, 2'b00, 1'b0, 32'hFC,  32'h0,        32'h00000078, 1'b0, 0, 1);

        // Reset during an in-flight store aborts it
        issue(1'b1, 2'b10, 1'b0, 32'h8,   32'hDEADBEEF, 32'h0,        1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_async_ready", 32'(ready), 32'd1);
        chk("abort_async_rvalid", 32'(rvalid), 32'd0);
        chk("abort_async_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_hold = 0;
        issue(1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'h00000008, 1'b0, 0, 1);

        // Back-to-back with req held high
        issue(1'b1, 2'b10, 1'b0, 32'h10,  32'h11111111, 32'h0,        1'b0, 1, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h11111111, 1'b0, 1, 1);
        issue(1'b1, 2'b01, 1'b0, 32'h12,  32'h0000BEEF, 32'h0,        1'b0, 1, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hBEEF1111, 1'b0, 1, 1);
        issue(1'b1, 2'b00, 1'b0, 32'h13,  32'h0000007F, 32'h0,        1'b0, 1, 1);
        issue(1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'h00007FEF, 1'b0, 1, 1);
        issue(1'b0, 2'b00, 1'b0, 32'h12,  32'h0,        32'hFFFFFFEF, 1'b0, 0, 1);

        repeat (8) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 64, meaning the number of 32-bit words (power of 2, 4..4096).
REQ-002 The block SHALL have the parameter WAIT, default 1, meaning extra access wait cycles (0..15).
REQ-003 The block SHALL have the port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have the port req  input  1  meaning the access request.
REQ-006 The block SHALL have the port ready  output  1  meaning the block can accept a request.
REQ-007 The block SHALL have the port we  input  1  meaning 1 = store, 0 = load.
REQ-008 The block SHALL have the port size  input  2  meaning the access width: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 The block SHALL have the port ld_unsigned  input  1  meaning zero-extend loads (1) or sign-extend loads (0).
REQ-010 The block SHALL have the port addr  input  32  meaning the byte address, little-endian.
REQ-011 The block SHALL have the port wdata  input  32  meaning the store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 The block SHALL have the port rvalid  output  1  meaning a one-cycle completion pulse for every accepted request.
REQ-013 The block SHALL have the port rdata  output  32  meaning the load result, qualified by rvalid.
REQ-014 The block SHALL have the port err  output  1  meaning the access faulted, qualified by rvalid.

Function
REQ-015 A request SHALL be accepted on a rising edge where req=1 and ready=1; at that edge addr, we, size, ld_unsigned and wdata SHALL be captured, and later changes to these inputs SHALL have no effect on the request.
REQ-016 The FSM SHALL have the states IDLE, BUSY and RESP; ready SHALL be 1 only in IDLE, and req SHALL be ignored in BUSY and RESP.
REQ-017 The FSM SHALL go IDLE->BUSY on acceptance, with the wait counter loaded to WAIT.
REQ-018 In BUSY the counter SHALL decrement each cycle; on the edge where the counter is 0 the access SHALL be performed, rdata/err registered, and the FSM SHALL go to RESP.
REQ-019 RESP SHALL last exactly one cycle with rvalid=1, then the FSM SHALL return to IDLE.
REQ-020 RESP SHALL be entered on edge E0+WAIT+1, where E0 is the acceptance edge; the minimum spacing of accepted requests SHALL be WAIT+3 cycles.
REQ-021 The word index SHALL be addr[31:2] and the lane SHALL be addr[1:0].
REQ-022 err=1 SHALL result when any of these hold: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:2] >= DEPTH.
REQ-023 On err=1 memory SHALL be unmodified and rdata SHALL be 0; err SHALL be 0 otherwise.
REQ-024 A store SHALL modify only the addressed byte lane(s); other bytes of the word SHALL be preserved.
REQ-025 A store response SHALL have rdata=0.
REQ-026 For a load byte, rdata SHALL be word[8*lane+7 : 8*lane], extended to 32 bits per ld_unsigned.
REQ-027 For a load half, rdata SHALL be word[8*lane+15 : 8*lane] for lane 0 or 2, extended to 32 bits per ld_unsigned.
REQ-028 For a load word, rdata SHALL be the full word, and ld_unsigned SHALL be ignored.
REQ-029 rdata and err SHALL hold their values between responses.
REQ-030 Initial memory contents SHALL be words 0..10 = 10,9,...,0 and all other words 0, set at configuration/simulation start only.

Reset
REQ-031 While rst_n=0, the FSM SHALL be IDLE, the counter 0, ready=1, rvalid=0, rdata=0 and err=0, all asynchronously.
REQ-032 Reset SHALL NOT alter memory contents.
REQ-033 Reset asserted mid-operation SHALL abort the in-flight request: no rvalid SHALL be produced, and a store whose access edge has not occurred SHALL NOT be committed.
REQ-034 After reset deasserts, the first accepted request SHALL be on the first rising edge with req=1.

Verification (WAIT=1, DEPTH=64)
REQ-035 The bench SHALL apply rst_n low, then a load word at 0x0 accepted at E0 -> ready=1, rvalid=0, rdata=0 during reset; rvalid=1 in the cycle after E2 with rdata=0x0000000A and err=0; ready=1 again the following cycle.
REQ-036 The bench SHALL store byte 0xA5 to 0x5, then load word 0x4, load byte 0x5 signed and load byte 0x5 unsigned -> rdata 0x0000A509, then 0xFFFFFFA5, then 0x000000A5.
REQ-037 The bench SHALL issue a load half at 0x3 and a store word 0xFFFFFFFF at 0x6, then load word 0x4 -> err=1 and rdata=0 for both faulting requests; the load word returns the prior value, unchanged.
REQ-038 The bench SHALL issue a load word at 0x100 and a request with size=11 at 0x0 -> err=1 and rdata=0 for both; no memory change.
REQ-039 The bench SHALL store word 0xDEADBEEF to 0x8 with rst_n pulsed low in the cycle after acceptance, then load word 0x8 -> no rvalid for the store; the load returns 0x00000008.
REQ-040 The bench SHALL hold req=1 continuously with alternating store and load -> acceptances exactly 4 cycles apart, one rvalid per acceptance, and no acceptance while ready=0.
